// File: rtl/stack_ram_ctrl_pkg.sv
// Shared constants and operation decode for the LIFO stack controller.
// The decode is kept here so every file classifies a cycle the same way.
package stack_ram_ctrl_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_OVF,
    OP_UNF
  } stack_op_e;

  // Push+pop on an empty stack degenerates to a plain push.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic full, input logic empty);
    if (push && pop && !empty) return OP_REPL;
    if (push)                  return full ? OP_OVF : OP_PUSH;
    if (pop)                   return empty ? OP_UNF : OP_POP;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/stack_ram_ctrl_stack_ptr.sv
// Stack pointer and occupancy counter; SP addresses the next free word.
// FULL/EMPTY come from the count only, since SP alone cannot tell them apart.
module stack_ptr
  import stack_ram_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] INIT_SP = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (inc_i) begin
      sp_d  = sp_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q  <= INIT_SP;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  assign sp_o    = sp_q;
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/stack_ram_ctrl.sv
// LIFO controller driving an external 32-deep single-port RAM (one cell per bit).
// RAM read data is asynchronous, so a pop captures the top word at the same edge.
module stack_ram_ctrl
  import stack_ram_ctrl_pkg::*;
#(
  parameter int                WIDTH   = 10,
  parameter logic [ADDR_W-1:0] INIT_SP = 5'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [WIDTH-1:0]  PUSH_DATA,
  input  logic              CLR_ERR,
  output logic [ADDR_W-1:0] ADR,
  output logic              WE,
  output logic [WIDTH-1:0]  RAM_I,
  input  logic [WIDTH-1:0]  RAM_O,
  output logic [WIDTH-1:0]  POP_DATA,
  output logic              POP_VALID,
  output logic [CNT_W-1:0]  COUNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  logic [ADDR_W-1:0] sp;
  stack_op_e         op;

  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  stack_ptr #(
    .INIT_SP (INIT_SP)
  ) u_stack_ptr (
    .clk_i   (CLK),
    .rst_i   (RST),
    .inc_i   (op == OP_PUSH),
    .dec_i   (op == OP_POP),
    .sp_o    (sp),
    .cnt_o   (COUNT),
    .full_o  (FULL),
    .empty_o (EMPTY)
  );

  assign op = decode_op(PUSH, POP, FULL, EMPTY);

  // Replace-top reads and rewrites SP-1 in the same cycle: old word is latched
  // from RAM_O at the edge that commits the new one.
  assign ADR   = (POP && !EMPTY) ? sp - 1'b1 : sp;
  assign WE    = !RST && ((op == OP_PUSH) || (op == OP_REPL));
  assign RAM_I = PUSH_DATA;

  always_comb begin
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    if ((op == OP_POP) || (op == OP_REPL)) begin
      pop_data_d  = RAM_O;
      pop_valid_d = 1'b1;
    end
    // A new error wins over a coincident clear.
    ovf_d = (ovf_q && !CLR_ERR) || (op == OP_OVF);
    unf_d = (unf_q && !CLR_ERR) || (op == OP_UNF);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign POP_DATA  = pop_data_q;
  assign POP_VALID = pop_valid_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_stack_ram_ctrl.sv
// Bench for stack_ram_ctrl: external RAM array, queue-based stack model checked
// every falling edge, plus directed sequences with literal expectations.
module tb_stack_ram_ctrl;

  localparam int         WIDTH   = 10;
  localparam logic [4:0] INIT_SP = 5'h00;

  logic             CLK;
  logic             RST;
  logic             PUSH, POP, CLR_ERR;
  logic [WIDTH-1:0] PUSH_DATA;
  logic [4:0]       ADR;
  logic             WE;
  logic [WIDTH-1:0] RAM_I, RAM_O, POP_DATA;
  logic             POP_VALID;
  logic [5:0]       COUNT;
  logic             FULL, EMPTY, OVERFLOW, UNDERFLOW;

  stack_ram_ctrl #(.WIDTH(WIDTH), .INIT_SP(INIT_SP)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PUSH      (PUSH),
    .POP       (POP),
    .PUSH_DATA (PUSH_DATA),
    .CLR_ERR   (CLR_ERR),
    .ADR       (ADR),
    .WE        (WE),
    .RAM_I     (RAM_I),
    .RAM_O     (RAM_O),
    .POP_DATA  (POP_DATA),
    .POP_VALID (POP_VALID),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External RAM cells: asynchronous read, write on rising edge.
  logic [WIDTH-1:0] ram [32];
  initial for (int i = 0; i < 32; i++) ram[i] = '0;
  assign RAM_O = ram[ADR];
  always @(posedge CLK) if (WE) ram[ADR] <= RAM_I;

  int n_checks = 0;
  int n_err    = 0;
  bit run      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the stack is a queue, SP is INIT_SP plus occupancy.
  logic [WIDTH-1:0] m_stack[$];
  logic [WIDTH-1:0] m_pd  = '0;
  logic             m_pv  = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic             m_ovf_hit, m_unf_hit;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_stack.delete();
      m_pd  = '0;
      m_pv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_pv      = 1'b0;
      m_ovf_hit = 1'b0;
      m_unf_hit = 1'b0;
      if (PUSH && POP && m_stack.size() != 0) begin
        m_pd         = m_stack[$];
        m_pv         = 1'b1;
        m_stack[$]   = PUSH_DATA;
      end else if (PUSH) begin
        if (m_stack.size() < 32) m_stack.push_back(PUSH_DATA);
        else                     m_ovf_hit = 1'b1;
      end else if (POP) begin
        if (m_stack.size() != 0) begin
          m_pd = m_stack.pop_back();
          m_pv = 1'b1;
        end else m_unf_hit = 1'b1;
      end
      m_ovf = m_ovf_hit || (m_ovf && !CLR_ERR);
      m_unf = m_unf_hit || (m_unf && !CLR_ERR);
    end
  end

  logic [4:0] e_sp, e_adr;
  logic       e_we;
  always @(negedge CLK) begin
    if (run) begin
      e_sp  = INIT_SP + 5'(m_stack.size());
      e_adr = (POP && m_stack.size() != 0) ? e_sp - 5'd1 : e_sp;
      e_we  = !RST && PUSH && (m_stack.size() < 32 || (POP && m_stack.size() != 0));
      check("m_count",     COUNT,     32'(m_stack.size()));
      check("m_full",      FULL,      32'(m_stack.size() == 32));
      check("m_empty",     EMPTY,     32'(m_stack.size() == 0));
      check("m_pop_data",  POP_DATA,  m_pd);
      check("m_pop_valid", POP_VALID, m_pv);
      check("m_overflow",  OVERFLOW,  m_ovf);
      check("m_underflow", UNDERFLOW, m_unf);
      check("m_adr",       ADR,       e_adr);
      check("m_we",        WE,        e_we);
      check("m_ram_i",     RAM_I,     PUSH_DATA);
    end
  end

  task automatic set_in(input logic pu, input logic po, input logic [WIDTH-1:0] d, input logic clr);
    PUSH = pu; POP = po; PUSH_DATA = d; CLR_ERR = clr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic pu, input logic po, input logic [WIDTH-1:0] d, input logic clr);
    set_in(pu, po, d, clr);
    tick();
  endtask

  logic [WIDTH-1:0] snap;

  initial begin
    set_in(0, 0, '0, 0);
    RST = 1'b0;
    #2 RST = 1'b1;
    #1 run = 1'b1;
    check("rst_count", COUNT, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_pop_data", POP_DATA, 0);
    check("rst_adr", ADR, 32'(INIT_SP));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 1; i <= 32; i++) step(1, 0, WIDTH'(i), 0);
    set_in(0, 0, '0, 0);
    #1;
    check("fill_count", COUNT, 32);
    check("fill_full", FULL, 1);
    check("fill_adr", ADR, 0);
    check("fill_ovf", OVERFLOW, 0);

    set_in(1, 0, 10'h3FF, 0);
    #1 check("ovf_we", WE, 0);
    tick();
    check("ovf_flag", OVERFLOW, 1);
    check("ovf_count", COUNT, 32);
    step(1, 0, 10'h3FF, 1);
    check("ovf_clr_collide", OVERFLOW, 1);
    step(0, 0, '0, 1);
    check("ovf_clr", OVERFLOW, 0);

    for (int i = 32; i >= 1; i--) begin
      step(0, 1, '0, 0);
      check("pop_data", POP_DATA, i);
      check("pop_valid", POP_VALID, 1);
    end
    step(0, 0, '0, 0);
    check("drain_valid", POP_VALID, 0);
    check("drain_empty", EMPTY, 1);

    step(0, 1, '0, 0);
    check("unf_flag", UNDERFLOW, 1);
    check("unf_valid", POP_VALID, 0);
    check("unf_pop_data", POP_DATA, 10'h001);
    step(0, 0, '0, 1);
    check("unf_clr", UNDERFLOW, 0);

    step(1, 0, 10'h0AA, 0);
    step(1, 1, 10'h155, 0);
    check("repl_data", POP_DATA, 10'h0AA);
    check("repl_valid", POP_VALID, 1);
    check("repl_count", COUNT, 1);
    step(0, 1, '0, 0);
    check("repl_next_pop", POP_DATA, 10'h155);
    check("repl_empty", COUNT, 0);

    step(1, 1, 10'h077, 0);
    check("pp_empty_valid", POP_VALID, 0);
    check("pp_empty_count", COUNT, 1);
    check("pp_empty_unf", UNDERFLOW, 0);
    step(0, 1, '0, 0);
    check("pp_empty_pop", POP_DATA, 10'h077);

    for (int i = 0; i < 5; i++) step(1, 0, WIDTH'(10'h040 + i), 0);
    set_in(1, 0, 10'h123, 0);
    snap = ram[5];
    #2 RST = 1'b1;
    #1;
    check("mid_rst_count", COUNT, 0);
    check("mid_rst_we", WE, 0);
    check("mid_rst_valid", POP_VALID, 0);
    check("mid_rst_ovf", OVERFLOW, 0);
    tick();
    check("mid_rst_ram", ram[5], snap);
    RST = 1'b0;
    step(1, 0, 10'h0F0, 0);
    step(0, 1, '0, 0);
    check("post_rst_pop", POP_DATA, 10'h0F0);
    step(0, 0, '0, 0);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
